// File: rtl/jtopl_eg_pkg.sv
// Shared definitions for the envelope controller: phase encoding, slot record,
// step patterns and the effective-rate helper.
package jtopl_eg_pkg;

  localparam int R6W   = 6;
  localparam int RATEW = 5;
  localparam int BASEW = 4;
  localparam int KCW   = 4;

  typedef enum logic [1:0] {
    EG_ATTACK  = 2'd0,
    EG_DECAY   = 2'd1,
    EG_SUSTAIN = 2'd2,
    EG_RELEASE = 2'd3
  } eg_state_e;

  typedef struct packed {
    eg_state_e st;
    logic      keyon_last;
  } slot_rec_t;

  // Step pattern row selected by the two fractional rate bits.
  function automatic logic [7:0] eg_pat(input logic [1:0] idx);
    logic [7:0] row;
    case (idx)
      2'd0:    row = 8'b10101010;
      2'd1:    row = 8'b11101010;
      2'd2:    row = 8'b11101110;
      default: row = 8'b11111110;
    endcase
    return row;
  endfunction

  // Sum is formed in 7 bits so 4*15+15 saturates to 63 instead of wrapping.
  function automatic logic [R6W-1:0] eg_rate6(input logic [BASEW-1:0] base,
                                             input logic             ksr,
                                             input logic [KCW-1:0]   keycode);
    logic [6:0] sum;
    sum = {1'b0, base, 2'b00} + (ksr ? {3'b000, keycode} : {5'b00000, keycode[3:2]});
    if (base == '0) begin
      return '0;
    end else if (sum > 7'd63) begin
      return 6'd63;
    end else begin
      return sum[R6W-1:0];
    end
  endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// Combinational step/sum_up generator: maps the 6-bit effective rate and the
// global envelope counter onto the update gate and the pattern step bit.
module jtopl_eg_step
  import jtopl_eg_pkg::*;
#(
  parameter int CNTW = 15
) (
  input  logic [R6W-1:0]  r6_i,
  input  logic [CNTW-1:0] cnt_i,
  output logic            step_o,
  output logic            sum_up_o
);

  logic [7:0]      pattern;
  logic [3:0]      sh;
  logic [2:0]      sel;
  logic [CNTW-1:0] mask;
  logic [CNTW-1:0] shifted;

  always_comb begin
    pattern  = eg_pat(r6_i[1:0]);
    sh       = 4'd0;
    mask     = '0;
    shifted  = cnt_i;
    sel      = cnt_i[2:0];
    step_o   = 1'b0;
    sum_up_o = 1'b0;
    if (r6_i != '0) begin
      // Slow rates only update every 2^sh counts and take pattern bits above the mask.
      if (r6_i[5:2] < 4'd12) begin
        sh       = 4'd11 - r6_i[5:2];
        mask     = (CNTW'(1) << sh) - CNTW'(1);
        shifted  = cnt_i >> sh;
        sel      = shifted[2:0];
        sum_up_o = (cnt_i & mask) == '0;
      end else begin
        sum_up_o = 1'b1;
      end
      step_o = pattern[sel];
    end
  end

endmodule

// File: rtl/jtopl_eg_ctrl.sv
// Envelope controller: global counter, per-slot ADSR phase ring and registered
// rate/step outputs. Optional JTOPL_EG_CNT_FREEZE_EN adds a cnt_freeze input.
module jtopl_eg_ctrl
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int CNTW  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             zero,
`ifdef JTOPL_EG_CNT_FREEZE_EN
  input  logic             cnt_freeze,
`endif
  input  logic             keyon_I,
  input  logic             en_sus_I,
  input  logic             ksr_I,
  input  logic [KCW-1:0]   keycode_I,
  input  logic [BASEW-1:0] arate_I,
  input  logic [BASEW-1:0] drate_I,
  input  logic [BASEW-1:0] rrate_I,
  input  logic [3:0]       sl_I,
  input  logic [9:0]       eg_in,
  output logic             attack,
  output logic             step,
  output logic [RATEW-1:0] rate,
  output logic             sum_up,
  output logic [1:0]       state
);

  logic [CNTW-1:0]  cnt_q, cnt_d;
  slot_rec_t        ring_q [SLOTS];
  slot_rec_t        head;
  eg_state_e        st_d;
  logic [BASEW-1:0] base;
  logic [R6W-1:0]   r6;
  logic             step_d, sum_up_d;
  logic             cnt_hold;

  logic             attack_q, step_q, sum_up_q;
  logic [RATEW-1:0] rate_q;
  eg_state_e        state_q;

`ifdef JTOPL_EG_CNT_FREEZE_EN
  assign cnt_hold = cnt_freeze;
`else
  assign cnt_hold = 1'b0;
`endif

  // Counter value 0 only exists right after reset; a wrap lands on 1.
  always_comb begin
    cnt_d = cnt_q;
    if (cen && zero && !cnt_hold) begin
      cnt_d = cnt_q + CNTW'(1);
      if (cnt_d == '0) begin
        cnt_d = CNTW'(1);
      end
    end
  end

  always_comb begin
    head = ring_q[SLOTS-1];
    st_d = head.st;
    if (keyon_I && !head.keyon_last) begin
      st_d = EG_ATTACK;
    end else if (!keyon_I) begin
      st_d = EG_RELEASE;
    end else if (head.st == EG_ATTACK && eg_in == '0) begin
      st_d = EG_DECAY;
    end else if (head.st == EG_DECAY && eg_in[9:5] >= {&sl_I, sl_I}) begin
      st_d = EG_SUSTAIN;
    end

    case (st_d)
      EG_ATTACK:  base = arate_I;
      EG_DECAY:   base = drate_I;
      EG_SUSTAIN: base = en_sus_I ? '0 : rrate_I;
      default:    base = rrate_I;
    endcase
    r6 = eg_rate6(base, ksr_I, keycode_I);
  end

  jtopl_eg_step #(
    .CNTW(CNTW)
  ) u_step (
    .r6_i     (r6),
    .cnt_i    (cnt_q),
    .step_o   (step_d),
    .sum_up_o (sum_up_d)
  );

  // The ring is a plain shift register, so a slot's record returns to the head
  // exactly SLOTS cen cycles later regardless of where zero pulses land.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ring_q[i] <= '{st: EG_RELEASE, keyon_last: 1'b0};
      end
      attack_q <= 1'b0;
      step_q   <= 1'b0;
      sum_up_q <= 1'b0;
      rate_q   <= '0;
      state_q  <= EG_RELEASE;
    end else begin
      cnt_q <= cnt_d;
      if (cen) begin
        ring_q[0] <= '{st: st_d, keyon_last: keyon_I};
        for (int i = 1; i < SLOTS; i++) begin
          ring_q[i] <= ring_q[i-1];
        end
        attack_q <= (st_d == EG_ATTACK);
        step_q   <= step_d;
        sum_up_q <= sum_up_d;
        rate_q   <= r6[5:1];
        state_q  <= st_d;
      end
    end
  end

  assign attack = attack_q;
  assign step   = step_q;
  assign sum_up = sum_up_q;
  assign rate   = rate_q;
  assign state  = state_q;

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// Self-checking bench for jtopl_eg_ctrl: directed slot scenarios plus random
// traffic compared against a per-slot behavioural model.
module tb_jtopl_eg_ctrl;
  localparam int SLOTS = 18;
  localparam int CNTW  = 15;

  logic       clk = 1'b0;
  logic       rst, cen, zero, keyon_I, en_sus_I, ksr_I;
  logic [3:0] keycode_I, arate_I, drate_I, rrate_I, sl_I;
  logic [9:0] eg_in;
  logic       attack, step, sum_up;
  logic [4:0] rate;
  logic [1:0] state;
`ifdef JTOPL_EG_CNT_FREEZE_EN
  logic       cnt_freeze;
`endif

  typedef struct {
    bit cen;
    bit zero_force;
    bit keyon;
    bit en_sus;
    bit ksr;
    int keycode;
    int ar;
    int dr;
    int rr;
    int sl;
    int egin;
    bit freeze;
  } stim_t;

  int mPhase [SLOTS];
  bit mKlast [SLOTS];
  int mCnt;
  int slotIdx;
  int expState, expRate;
  bit expAttack, expStep, expSum;
  int pat [4] = '{8'hAA, 8'hEA, 8'hEE, 8'hFE};
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jtopl_eg_ctrl #(.SLOTS(SLOTS), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
`ifdef JTOPL_EG_CNT_FREEZE_EN
    .cnt_freeze(cnt_freeze),
`endif
    .keyon_I   (keyon_I),
    .en_sus_I  (en_sus_I),
    .ksr_I     (ksr_I),
    .keycode_I (keycode_I),
    .arate_I   (arate_I),
    .drate_I   (drate_I),
    .rrate_I   (rrate_I),
    .sl_I      (sl_I),
    .eg_in     (eg_in),
    .attack    (attack),
    .step      (step),
    .rate      (rate),
    .sum_up    (sum_up),
    .state     (state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dutOuts();
    return {22'd0, state, attack, step, sum_up, rate};
  endfunction

  function automatic stim_t idleStim();
    stim_t st;
    st.cen = 1'b1; st.zero_force = 1'b0; st.keyon = 1'b0; st.en_sus = 1'b0;
    st.ksr = 1'b0; st.keycode = 0; st.ar = 0; st.dr = 0; st.rr = 0; st.sl = 0;
    st.egin = 'h3FF; st.freeze = 1'b0;
    return st;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < SLOTS; i++) begin
      mPhase[i] = 3;
      mKlast[i] = 1'b0;
    end
    mCnt = 0; slotIdx = 0;
    expState = 3; expRate = 0; expAttack = 0; expStep = 0; expSum = 0;
  endfunction

  // Reference: phases 0..3 = attack/decay/sustain/release, rates by plain arithmetic.
  function automatic void modelStep(input stim_t st, input bit z, input int s);
    int ph, base, r6, hi, sh, sel, slTarget;
    ph = mPhase[s];
    slTarget = (st.sl == 15) ? 31 : st.sl;
    if (st.keyon && !mKlast[s])                    ph = 0;
    else if (!st.keyon)                            ph = 3;
    else if (ph == 0 && st.egin == 0)              ph = 1;
    else if (ph == 1 && (st.egin / 32) >= slTarget) ph = 2;
    mPhase[s] = ph;
    mKlast[s] = st.keyon;
    case (ph)
      0:       base = st.ar;
      1:       base = st.dr;
      2:       base = st.en_sus ? 0 : st.rr;
      default: base = st.rr;
    endcase
    if (base == 0) r6 = 0;
    else begin
      r6 = 4 * base + (st.ksr ? st.keycode : st.keycode / 4);
      if (r6 > 63) r6 = 63;
    end
    expState = ph; expAttack = (ph == 0); expRate = r6 / 2;
    if (r6 == 0) begin
      expSum = 0; expStep = 0;
    end else begin
      hi = r6 / 4;
      if (hi < 12) begin
        sh = 11 - hi;
        expSum = (mCnt % (1 << sh)) == 0;
        sel = (mCnt >> sh) % 8;
      end else begin
        expSum = 1;
        sel = mCnt % 8;
      end
      expStep = ((pat[r6 % 4] >> sel) & 1) != 0;
    end
    if (z && !st.freeze) begin
      mCnt = mCnt + 1;
      if (mCnt == (1 << CNTW)) mCnt = 1;
    end
  endfunction

  task automatic applyStimulus(input stim_t st);
    bit z;
    z = st.cen && (slotIdx == 0 || st.zero_force);
    cen = st.cen; zero = z; keyon_I = st.keyon; en_sus_I = st.en_sus; ksr_I = st.ksr;
    keycode_I = 4'(st.keycode); arate_I = 4'(st.ar); drate_I = 4'(st.dr);
    rrate_I = 4'(st.rr); sl_I = 4'(st.sl); eg_in = 10'(st.egin);
`ifdef JTOPL_EG_CNT_FREEZE_EN
    cnt_freeze = st.freeze;
`endif
    if (st.cen) begin
      modelStep(st, z, slotIdx);
      slotIdx = (slotIdx + 1) % SLOTS;
    end
    @(negedge clk);
    checkOutput("outs", dutOuts(),
                {22'd0, 2'(expState), expAttack, expStep, expSum, 5'(expRate)});
  endtask

  task automatic doReset();
    rst = 1'b1; cen = 1'b0; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("reset", dutOuts(), 32'h300);
  endtask

  initial begin
    stim_t st;
    int    ups;
    bit    rKey [SLOTS];

    rst = 1'b0; cen = 1'b0; zero = 1'b0; keyon_I = 1'b0; en_sus_I = 1'b0; ksr_I = 1'b0;
    keycode_I = '0; arate_I = '0; drate_I = '0; rrate_I = '0; sl_I = '0; eg_in = '0;
`ifdef JTOPL_EG_CNT_FREEZE_EN
    cnt_freeze = 1'b0;
`endif
    @(negedge clk);
    doReset();

    for (int c = 0; c < 2 * SLOTS; c++) begin
      applyStimulus(idleStim());
      checkOutput("idle", dutOuts(), 32'h300);
    end

    // Directed frames 2..5 exercise slots 3, 5 and 7 through the phase boundaries.
    for (int f = 2; f <= 5; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        st = idleStim();
        if (s == 3) begin
          st.keyon = 1'b1;
          case (f)
            2: st.ar = 15;
            3: st.egin = 0;
            4: begin st.dr = 4; st.sl = 2; st.egin = 'h040; st.en_sus = 1'b1; end
            default: st.rr = 7;
          endcase
        end
        if (s == 5) begin
          st.keyon = 1'b1;
          if (f <= 3) st.egin = 0;
          if (f == 4) begin st.sl = 15; st.egin = 'h3FF; end
        end
        if (s == 7 && f == 5) begin st.rr = 15; st.ksr = 1'b1; st.keycode = 15; end
        applyStimulus(st);
        if (s == 3 && f == 2) begin
          checkOutput("keyon_attack", 32'(attack), 32'd1);
          checkOutput("attack_rate", 32'(rate), 32'h1E);
          checkOutput("attack_sum_up", 32'(sum_up), 32'd1);
        end
        if (s == 3 && f == 3) begin
          checkOutput("to_decay_state", 32'(state), 32'd1);
          checkOutput("to_decay_attack", 32'(attack), 32'd0);
        end
        if (s == 3 && f == 4) begin
          checkOutput("to_sustain_state", 32'(state), 32'd2);
          checkOutput("sustain_hold_sum_up", 32'(sum_up), 32'd0);
        end
        if (s == 3 && f == 5) checkOutput("sustain_rr_rate", 32'(rate), 32'd14);
        if (s == 5 && f == 2) checkOutput("keyon_at_zero_attack", 32'(attack), 32'd1);
        if (s == 5 && f == 3) checkOutput("keyon_at_zero_decay", 32'(state), 32'd1);
        if (s == 5 && f == 4) checkOutput("sl15_sustain", 32'(state), 32'd2);
        if (s == 7 && f == 5) begin
          checkOutput("sat_rate", 32'(rate), 32'd31);
          checkOutput("sat_sum_up", 32'(sum_up), 32'd1);
        end
      end
    end

    // Slowest nonzero rate (r6=4) on slot 9 should update twice in 2048 frames.
    ups = 0;
    for (int f = 0; f < 2048; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        st = idleStim();
        if (s == 9) st.rr = 1;
        applyStimulus(st);
        if (s == 9 && sum_up) ups++;
        if (s == 9 && f == 0) checkOutput("slow_rate", 32'(rate), 32'd2);
      end
    end
    checkOutput("slow_updates", 32'(ups), 32'd2);

    // Random traffic, with a stray zero pulse and a mid-frame reset along the way.
    for (int i = 0; i < SLOTS; i++) rKey[i] = 1'b0;
    for (int c = 0; c < 5400; c++) begin
      if (c == 2707) begin
        doReset();
        for (int i = 0; i < SLOTS; i++) rKey[i] = 1'b0;
      end
      st = idleStim();
      st.cen = ($urandom_range(7) != 0);
      if ($urandom_range(7) == 0) rKey[slotIdx] = ~rKey[slotIdx];
      st.keyon   = rKey[slotIdx];
      st.en_sus  = 1'($urandom_range(1));
      st.ksr     = 1'($urandom_range(1));
      st.keycode = int'($urandom_range(15));
      st.ar      = int'($urandom_range(15));
      st.dr      = int'($urandom_range(15));
      st.rr      = int'($urandom_range(15));
      st.sl      = int'($urandom_range(15));
      st.egin    = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(1023));
      st.zero_force = (c >= 700 && c < 720 && slotIdx == 5);
`ifdef JTOPL_EG_CNT_FREEZE_EN
      st.freeze  = (c >= 1000 && c < 1400);
`endif
      applyStimulus(st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
